// File: rtl/shooter_pkg.sv
// Shared constants, types and FSM states for the space-shooter display path.
package shooter_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    localparam int unsigned PX_W    = 8;
    localparam int unsigned PY_W    = 7;
    localparam int unsigned COL_W   = 3;
    localparam int unsigned DIM_W   = 4;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned NUM_OBJ = 5;

    typedef logic [COL_W-1:0] colour_t;

    localparam colour_t COL_BLACK  = 3'b000;
    localparam colour_t COL_SHIP   = 3'b010;
    localparam colour_t COL_ROCKET = 3'b110;
    localparam colour_t COL_ALIEN  = 3'b100;

    localparam int unsigned DEF_SHIP_W   = 8;
    localparam int unsigned DEF_SHIP_H   = 4;
    localparam int unsigned DEF_ROCKET_W = 1;
    localparam int unsigned DEF_ROCKET_H = 4;
    localparam int unsigned DEF_ALIEN_W  = 6;
    localparam int unsigned DEF_ALIEN_H  = 4;

    localparam logic [IDX_W-1:0] OBJ_SHIP   = 3'd0;
    localparam logic [IDX_W-1:0] OBJ_ROCKET = 3'd1;
    localparam logic [IDX_W-1:0] OBJ_LAST   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_ERASE,
        ST_DRAW,
        ST_NEXT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [PX_W-1:0] x;
        logic [PY_W-1:0] y;
        colour_t         colour;
    } pixel_t;

endpackage

// File: rtl/sprite_painter_if.sv
// Single-pixel framebuffer write bus towards vga_adapter.
interface sprite_painter_if;
    import shooter_pkg::*;

    pixel_t pix;
    logic   plot;

    modport master (output pix, output plot);
    modport slave  (input pix, input plot);
endinterface

// File: rtl/sprite_painter_rect_scanner.sv
// Row-major rectangle stepper: one (dx, dy) per cycle while start is held high.
module rect_scanner
    import shooter_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [DIM_W-1:0] w,
    input  logic [DIM_W-1:0] h,
    output logic [DIM_W-1:0] dx,
    output logic [DIM_W-1:0] dy,
    output logic             active,
    output logic             last
);

    logic row_end;

    // Position flags derived from the current counters.
    assign row_end = (dx == w - DIM_W'(1));
    assign active  = start;
    assign last    = start && row_end && (dy == h - DIM_W'(1));

    // Counters restart at the origin whenever a scan ends or is not running.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            dx <= '0;
            dy <= '0;
        end else if (!start || last) begin
            dx <= '0;
            dy <= '0;
        end else if (row_end) begin
            dx <= '0;
            dy <= dy + DIM_W'(1);
        end else begin
            dx <= dx + DIM_W'(1);
        end
    end

endmodule

// File: rtl/sprite_painter.sv
// Per-frame erase/redraw of ship, rocket and three aliens into the framebuffer.
module sprite_painter
    import shooter_pkg::*;
#(
    parameter int unsigned SHIP_W   = DEF_SHIP_W,
    parameter int unsigned SHIP_H   = DEF_SHIP_H,
    parameter int unsigned ROCKET_W = DEF_ROCKET_W,
    parameter int unsigned ROCKET_H = DEF_ROCKET_H,
    parameter int unsigned ALIEN_W  = DEF_ALIEN_W,
    parameter int unsigned ALIEN_H  = DEF_ALIEN_H
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          tick,
    input  logic [9:0]    ship_x,
    input  logic [8:0]    ship_y,
    input  logic [9:0]    rocket_x,
    input  logic [8:0]    rocket_y,
    input  logic          rocket_vis,
    input  logic [29:0]   alien_x,
    input  logic [26:0]   alien_y,
    input  logic [2:0]    alien_vis,
    sprite_painter_if.master vga,
    output logic          busy,
    output logic          done,
    output logic          overrun
);

    state_t state, state_n;

    logic [NUM_OBJ-1:0][PX_W-1:0] new_px, old_px;
    logic [NUM_OBJ-1:0][PY_W-1:0] new_py, old_py;
    logic [NUM_OBJ-1:0]           new_vis, old_vis;
    logic [IDX_W-1:0]             idx, idx_nxt;

    logic             scan_run, scan_active, scan_last;
    logic [DIM_W-1:0] obj_w, obj_h, dx, dy;
    logic [PX_W-1:0]  base_px;
    logic [PY_W-1:0]  base_py;
    logic [PX_W:0]    sum_x;
    logic [PY_W:0]    sum_y;
    logic             in_bounds;
    colour_t          obj_col;

    pixel_t pix_c;
    logic   plot_c, busy_c, done_c, overrun_c;

    assign scan_run = (state == ST_ERASE) || (state == ST_DRAW);
    assign idx_nxt  = idx + IDX_W'(1);

    rect_scanner u_scan (
        .clk    (clk),
        .resetn (resetn),
        .start  (scan_run),
        .w      (obj_w),
        .h      (obj_h),
        .dx     (dx),
        .dy     (dy),
        .active (scan_active),
        .last   (scan_last)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) state <= ST_IDLE;
        else        state <= state_n;
    end

    // Next state, per-object geometry and the pixel about to be written.
    always_comb begin
        state_n   = state;
        pix_c     = '0;
        plot_c    = 1'b0;
        busy_c    = (state != ST_IDLE);
        done_c    = (state == ST_DONE);
        overrun_c = tick && (state != ST_IDLE);

        case (idx)
            OBJ_SHIP: begin
                obj_w = DIM_W'(SHIP_W);   obj_h = DIM_W'(SHIP_H);   obj_col = COL_SHIP;
            end
            OBJ_ROCKET: begin
                obj_w = DIM_W'(ROCKET_W); obj_h = DIM_W'(ROCKET_H); obj_col = COL_ROCKET;
            end
            default: begin
                obj_w = DIM_W'(ALIEN_W);  obj_h = DIM_W'(ALIEN_H);  obj_col = COL_ALIEN;
            end
        endcase

        base_px   = (state == ST_ERASE) ? old_px[idx] : new_px[idx];
        base_py   = (state == ST_ERASE) ? old_py[idx] : new_py[idx];
        sum_x     = (PX_W+1)'(base_px) + (PX_W+1)'(dx);
        sum_y     = (PY_W+1)'(base_py) + (PY_W+1)'(dy);
        in_bounds = (sum_x < (PX_W+1)'(SCREEN_W)) && (sum_y < (PY_W+1)'(SCREEN_H));

        if (scan_active) begin
            pix_c.x = sum_x[PX_W-1:0];
            pix_c.y = sum_y[PY_W-1:0];
            plot_c  = in_bounds;
        end

        case (state)
            ST_IDLE:  if (tick) state_n = ST_LATCH;
            ST_LATCH: state_n = old_vis[0] ? ST_ERASE : ST_DRAW;
            ST_ERASE: begin
                pix_c.colour = COL_BLACK;
                if (scan_last) state_n = new_vis[idx] ? ST_DRAW : ST_NEXT;
            end
            ST_DRAW: begin
                pix_c.colour = obj_col;
                if (scan_last) state_n = ST_NEXT;
            end
            ST_NEXT: begin
                if (idx == OBJ_LAST)        state_n = ST_DONE;
                else if (old_vis[idx_nxt])  state_n = ST_ERASE;
                else if (new_vis[idx_nxt])  state_n = ST_DRAW;
                else                        state_n = ST_NEXT;
            end
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Object snapshot at LATCH and old/new hand-over at NEXT.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            new_px  <= '0;
            new_py  <= '0;
            old_px  <= '0;
            old_py  <= '0;
            new_vis <= '0;
            old_vis <= '0;
            idx     <= '0;
        end else if (state == ST_LATCH) begin
            new_px[0] <= ship_x[9:2];
            new_py[0] <= ship_y[8:2];
            new_px[1] <= rocket_x[9:2];
            new_py[1] <= rocket_y[8:2];
            for (int i = 0; i < 3; i++) begin
                new_px[2+i] <= alien_x[10*i+2 +: PX_W];
                new_py[2+i] <= alien_y[9*i+2 +: PY_W];
            end
            new_vis <= {alien_vis, rocket_vis, 1'b1};
            idx     <= '0;
        end else if (state == ST_NEXT) begin
            old_px[idx]  <= new_px[idx];
            old_py[idx]  <= new_py[idx];
            old_vis[idx] <= new_vis[idx];
            idx          <= idx_nxt;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            vga.pix  <= '0;
            vga.plot <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            vga.pix  <= pix_c;
            vga.plot <= plot_c;
            busy     <= busy_c;
            done     <= done_c;
            overrun  <= overrun_c;
        end
    end

endmodule

// File: tb/tb_sprite_painter.sv
// Directed bench for sprite_painter: frame passes, erase/redraw, clipping, overrun, reset.
module tb_sprite_painter;
    import shooter_pkg::*;

    logic        clk = 1'b0;
    logic        resetn, tick;
    logic [9:0]  ship_x, rocket_x;
    logic [8:0]  ship_y, rocket_y;
    logic        rocket_vis;
    logic [29:0] alien_x;
    logic [26:0] alien_y;
    logic [2:0]  alien_vis;
    logic        busy, done, overrun;

    sprite_painter_if bus ();

    sprite_painter dut (
        .clk        (clk),
        .resetn     (resetn),
        .tick       (tick),
        .ship_x     (ship_x),
        .ship_y     (ship_y),
        .rocket_x   (rocket_x),
        .rocket_y   (rocket_y),
        .rocket_vis (rocket_vis),
        .alien_x    (alien_x),
        .alien_y    (alien_y),
        .alien_vis  (alien_vis),
        .vga        (bus),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Per-frame statistics.
    int n_green, n_red, n_yellow, n_black, n_plot, n_offscreen;
    int first_plot_k, first_green_k, first_yellow_k, first_red_k;
    int fg_x, fg_y, lg_x, lg_y, fb_x, fb_y, fr_x, fr_y, fy_x, fy_y, ly_x, ly_y;
    int done_k, done_cnt, overrun_k, overrun_cnt, timed_out, busy_before;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue a tick, then watch the pass; optional second tick and mid-pass reset.
    task automatic run_frame(input int tick2_k, input int rst_k);
        n_green = 0; n_red = 0; n_yellow = 0; n_black = 0; n_plot = 0; n_offscreen = 0;
        first_plot_k = -1; first_green_k = -1; first_yellow_k = -1; first_red_k = -1;
        fg_x = -1; fg_y = -1; lg_x = -1; lg_y = -1; fb_x = -1; fb_y = -1;
        fr_x = -1; fr_y = -1; fy_x = -1; fy_y = -1; ly_x = -1; ly_y = -1;
        done_k = -1; done_cnt = 0; overrun_k = -1; overrun_cnt = 0;
        timed_out = 1; busy_before = 0;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (bus.plot) begin
                n_plot++;
                if (first_plot_k < 0) first_plot_k = k;
                if (int'(bus.pix.x) >= 160 || int'(bus.pix.y) >= 120) n_offscreen++;
                case (bus.pix.colour)
                    3'b010: begin
                        n_green++;
                        if (first_green_k < 0) begin
                            first_green_k = k; fg_x = bus.pix.x; fg_y = bus.pix.y;
                        end
                        lg_x = bus.pix.x; lg_y = bus.pix.y;
                    end
                    3'b000: begin
                        n_black++;
                        if (fb_x < 0) begin fb_x = bus.pix.x; fb_y = bus.pix.y; end
                    end
                    3'b100: begin
                        n_red++;
                        if (first_red_k < 0) begin
                            first_red_k = k; fr_x = bus.pix.x; fr_y = bus.pix.y;
                        end
                    end
                    3'b110: begin
                        n_yellow++;
                        if (first_yellow_k < 0) begin
                            first_yellow_k = k; fy_x = bus.pix.x; fy_y = bus.pix.y;
                        end
                        ly_x = bus.pix.x; ly_y = bus.pix.y;
                    end
                    default: ;
                endcase
            end
            if (done) begin done_cnt++; done_k = k; end
            if (overrun) begin overrun_cnt++; overrun_k = k; end
            if (k == rst_k) begin
                busy_before = busy;
                resetn = 1'b1;
                #1;
                check("rst_plot", int'(bus.plot), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                @(negedge clk);
                resetn = 1'b0;
                timed_out = 0;
                break;
            end
            if (k == tick2_k) tick = 1'b1;
            else              tick = 1'b0;
            if (!busy && k > 1) begin
                timed_out = 0;
                break;
            end
        end
        check("timeout", timed_out, 0);
    endtask

    initial begin
        resetn     = 1'b1;
        tick       = 1'b0;
        ship_x     = 10'd312;
        ship_y     = 9'd400;
        rocket_x   = 10'd0;
        rocket_y   = 9'd0;
        rocket_vis = 1'b0;
        alien_x    = {10'd360, 10'd430, 10'd500};
        alien_y    = {9'd150, 9'd150, 9'd150};
        alien_vis  = 3'b111;

        repeat (3) @(negedge clk);
        check("reset_plot", int'(bus.plot), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_ovr",  int'(overrun), 0);
        check("reset_x",    int'(bus.pix.x), 0);
        resetn = 1'b0;
        @(negedge clk);

        // First frame: nothing to erase.
        run_frame(0, 0);
        check("f1_green",     n_green, 32);
        check("f1_red",       n_red, 72);
        check("f1_black",     n_black, 0);
        check("f1_first_k",   first_plot_k, 2);
        check("f1_fg_x",      fg_x, 78);
        check("f1_fg_y",      fg_y, 100);
        check("f1_lg_x",      lg_x, 85);
        check("f1_lg_y",      lg_y, 103);
        check("f1_fr_x",      fr_x, 125);
        check("f1_fr_y",      fr_y, 37);
        check("f1_fr_k",      first_red_k, 36);
        check("f1_done_k",    done_k, 111);
        check("f1_done_cnt",  done_cnt, 1);
        check("f1_overrun",   overrun_cnt, 0);

        // Ship moves one framebuffer pixel right.
        ship_x = 10'd316;
        run_frame(0, 0);
        check("f2_black",     n_black, 104);
        check("f2_fb_x",      fb_x, 78);
        check("f2_fb_y",      fb_y, 100);
        check("f2_green",     n_green, 32);
        check("f2_fg_k",      first_green_k, 34);
        check("f2_fg_x",      fg_x, 79);
        check("f2_lg_x",      lg_x, 86);
        check("f2_red",       n_red, 72);
        check("f2_done_k",    done_k, 215);

        // Rocket appears.
        rocket_vis = 1'b1;
        rocket_x   = 10'd325;
        rocket_y   = 9'd396;
        run_frame(0, 0);
        check("f3_yellow",    n_yellow, 4);
        check("f3_fy_k",      first_yellow_k, 67);
        check("f3_fy_x",      fy_x, 81);
        check("f3_fy_y",      fy_y, 99);
        check("f3_ly_x",      ly_x, 81);
        check("f3_ly_y",      ly_y, 102);
        check("f3_black",     n_black, 104);
        check("f3_done_k",    done_k, 219);

        // Rocket gone: erased, not redrawn.
        rocket_vis = 1'b0;
        run_frame(0, 0);
        check("f4_yellow",    n_yellow, 0);
        check("f4_black",     n_black, 108);
        check("f4_done_k",    done_k, 219);

        // Ship at right edge: only its first column is on screen.
        ship_x = 10'd636;
        run_frame(0, 0);
        check("f5_green",     n_green, 4);
        check("f5_lg_x",      lg_x, 159);
        check("f5_lg_y",      lg_y, 103);
        check("f5_offscreen", n_offscreen, 0);
        check("f5_black",     n_black, 104);
        check("f5_done_k",    done_k, 215);

        // Second tick mid-pass is dropped.
        run_frame(10, 0);
        check("f6_ovr_cnt",   overrun_cnt, 1);
        check("f6_ovr_k",     overrun_k, 11);
        check("f6_done_cnt",  done_cnt, 1);
        check("f6_done_k",    done_k, 215);
        check("f6_green",     n_green, 4);
        check("f6_black",     n_black, 76);

        // Reset mid-pass.
        ship_x = 10'd316;
        run_frame(0, 20);
        check("f7_busy_pre",  busy_before, 1);
        @(negedge clk);

        // After reset nothing is erased.
        run_frame(0, 0);
        check("f8_black",     n_black, 0);
        check("f8_green",     n_green, 32);
        check("f8_fg_x",      fg_x, 79);
        check("f8_red",       n_red, 72);
        check("f8_done_k",    done_k, 111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
